// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and default sizing for the UART receiver.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs, reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampled UART receiver with parity/stop checking,
// start-glitch rejection, break handling and a valid/ready output register.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  tick,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] S_END = BW'(STOP_BITS - 1);
  rx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bcnt;
  logic [DATA_WIDTH-1:0] sh;
  logic                  s, pe, fe, samp, done, fe_n, load;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .arst_n(arst_n), .d(rx), .q(s));
  assign samp = tick && cnt == C_END;
  assign done = state == STOP && samp && bcnt == S_END;
  assign fe_n = fe | ~s;
  assign load = !data_valid || data_ready;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bcnt        <= '0;
      sh          <= '0;
      pe          <= 1'b0;
      fe          <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= done && !load;
      if (done && load) begin
        data_out   <= sh;
        parity_err <= pe;
        frame_err  <= fe_n;
        data_valid <= 1'b1;
      end else if (data_ready) data_valid <= 1'b0;
      // every tick advances cnt unless a state below restarts it
      if (tick) begin
        cnt <= cnt + 1'b1;
        case (state)
          IDLE: begin
            cnt <= '0;
            if (!s) begin
              state <= START;
              pe    <= 1'b0;
              fe    <= 1'b0;
            end
          end
          START: if (cnt == C_MID) begin
            cnt   <= '0;
            state <= s ? IDLE : DATA;
          end
          DATA: if (samp) begin
            cnt  <= '0;
            sh   <= {s, sh[DATA_WIDTH-1:1]};
            bcnt <= bcnt == B_END ? '0 : bcnt + 1'b1;
            if (bcnt == B_END) state <= PARITY_EN != 0 ? PARITY : STOP;
          end
          PARITY: if (samp) begin
            cnt   <= '0;
            pe    <= (^sh ^ s) != 1'(PARITY_ODD);
            state <= STOP;
          end
          STOP: if (samp) begin
            cnt  <= '0;
            fe   <= fe_n;
            bcnt <= done ? '0 : bcnt + 1'b1;
            if (done) state <= s ? IDLE : BREAK;
          end
          BREAK: begin
            cnt <= '0;
            if (s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
